// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART_TX byte transmitter among NUM_REQ sources.
// Optional feature: define UART_TX_ID_HEADER_EN to prefix every grant with header byte {4'hA, grant_id}.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int BURST_MAX = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy,
    output logic                 uart_send,
    output logic [7:0]           uart_data,
    input  logic                 uart_tx_done
);

`ifdef UART_TX_ID_HEADER_EN
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, NEXT, HDR} state_t;
`else
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, NEXT} state_t;
`endif

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic [ID_W-1:0]      grant_id_q, grant_id_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic                 busy_q, busy_d;
    logic                 send_q, send_d;
    logic                 last_q, last_d;
    logic [7:0]           data_q, data_d;
    logic [7:0]           burst_cnt_q, burst_cnt_d;

    logic [7:0]           lane [NUM_REQ];
    logic                 pick_found;
    logic [ID_W-1:0]      pick_idx;
    logic                 issue_go;
    logic [ID_W-1:0]      issue_idx;
    logic [7:0]           issue_base;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign lane[gi] = req_data[8*gi +: 8];
        end
    endgenerate

`ifdef UART_TX_ID_HEADER_EN
    function automatic logic [7:0] hdr_byte(input logic [ID_W-1:0] id);
        logic [7:0] b;
        b = 8'hA0;
        b[ID_W-1:0] = id;
        return b;
    endfunction
`endif

    // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        int              cand;
        logic [ID_W-1:0] cand_idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = ID_W'(cand);
            if (!pick_found && req_valid[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // ISSUE's pulses and byte are registered on entry so send, data and ready appear together in ISSUE.
    always_comb begin
        state_d     = state_q;
        req_ready_d = '0;
        grant_id_d  = grant_id_q;
        ptr_d       = ptr_q;
        busy_d      = busy_q;
        send_d      = 1'b0;
        last_d      = last_q;
        data_d      = data_q;
        burst_cnt_d = burst_cnt_q;
        issue_go    = 1'b0;
        issue_idx   = grant_id_q;
        issue_base  = burst_cnt_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_id_d  = pick_idx;
                    busy_d      = 1'b1;
                    burst_cnt_d = 8'd0;
`ifdef UART_TX_ID_HEADER_EN
                    state_d = HDR;
                    send_d  = 1'b1;
                    data_d  = hdr_byte(pick_idx);
                    last_d  = 1'b0;
`else
                    state_d    = ISSUE;
                    issue_go   = 1'b1;
                    issue_idx  = pick_idx;
                    issue_base = 8'd0;
`endif
                end
            end
            ISSUE: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (uart_tx_done) begin
                    if (last_q || (burst_cnt_q == 8'(BURST_MAX))) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        ptr_d   = (grant_id_q == ID_W'(NUM_REQ-1)) ? '0 : grant_id_q + ID_W'(1);
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            NEXT: begin
                if (req_valid[grant_id_q]) begin
                    state_d  = ISSUE;
                    issue_go = 1'b1;
                end
            end
`ifdef UART_TX_ID_HEADER_EN
            HDR: begin
                if (uart_tx_done) begin
                    state_d = NEXT;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue_go) begin
            send_d      = 1'b1;
            data_d      = lane[issue_idx];
            last_d      = req_last[issue_idx];
            req_ready_d = NUM_REQ'(1) << issue_idx;
            burst_cnt_d = issue_base + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= '0;
            grant_id_q  <= '0;
            ptr_q       <= '0;
            busy_q      <= 1'b0;
            send_q      <= 1'b0;
            last_q      <= 1'b0;
            data_q      <= 8'h00;
            burst_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            grant_id_q  <= grant_id_d;
            ptr_q       <= ptr_d;
            busy_q      <= busy_d;
            send_q      <= send_d;
            last_q      <= last_d;
            data_q      <= data_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign req_ready = req_ready_q;
    assign grant_id  = grant_id_q;
    assign busy      = busy_q;
    assign uart_send = send_q;
    assign uart_data = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a burst-level reference model predicts the byte stream on the UART side,
// and a UART_TX stand-in answers each send with a tx_done pulse after a random delay.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int NR   = 4;
    localparam int BMAX = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic [1:0]      grant_id;
    logic            busy;
    logic            uart_send;
    logic [7:0]      uart_data;
    logic            uart_tx_done;

    uart_tx_arbiter #(.NUM_REQ(NR), .ID_W(2), .BURST_MAX(BMAX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .grant_id     (grant_id),
        .busy         (busy),
        .uart_send    (uart_send),
        .uart_data    (uart_data),
        .uart_tx_done (uart_tx_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       hdr;
        logic       ends;
    } exp_t;

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [8:0] rq [NR][$];          // per-requester byte queue, bit 8 = last
    exp_t       exp_q [$];           // predicted UART byte stream
    int         m_ptr = 0;
    int         stall_mode = 0;      // 0 none, 1 random, 2 fixed 20-cycle gap
    int         stall_cnt [NR];
    int         dcnt [NR];
    int         ready_cnt [NR];
    int         cyc = 0;
    bit         uart_pend, busy_chk_pend, busy_exp, cur_ends, gap_track, stall_since, resume_pend;
    int         uart_cnt, done_cyc, resume_cyc;
    logic [7:0] cap_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_tb();
        for (int i = 0; i < NR; i++) begin
            rq[i].delete();
            stall_cnt[i] = 0;
            dcnt[i]      = 0;
            ready_cnt[i] = 0;
        end
        exp_q.delete();
        m_ptr         = 0;
        uart_pend     = 0;
        busy_chk_pend = 0;
        gap_track     = 0;
        resume_pend   = 0;
        stall_since   = 0;
        cur_ends      = 0;
        req_valid     = '0;
        req_data      = '0;
        req_last      = '0;
        uart_tx_done  = 1'b0;
    endtask

    task automatic push_msg(input int id, input int len);
        for (int j = 0; j < len; j++) begin
            rq[id].push_back({(j == len - 1), 8'($urandom)});
        end
    endtask

    // Reference: serve the first pending requester at/after the pointer for one burst
    // (ends at last or after BMAX bytes), then move the pointer past it.
    task automatic build_expected();
        int         pos [NR];
        int         g, c, n;
        bit         e;
        logic [8:0] b;
        for (int i = 0; i < NR; i++) pos[i] = 0;
        while (1) begin
            g = -1;
            for (int k = 0; k < NR; k++) begin
                c = (m_ptr + k) % NR;
                if (g < 0 && pos[c] < rq[c].size()) g = c;
            end
            if (g < 0) break;
`ifdef UART_TX_ID_HEADER_EN
            exp_q.push_back('{id: 2'(g), data: (8'hA0 | 8'(g)), hdr: 1'b1, ends: 1'b0});
`endif
            n = 0;
            e = 0;
            while (!e) begin
                b = rq[g][pos[g]];
                pos[g]++;
                n++;
                e = b[8] || (n == BMAX);
                exp_q.push_back('{id: 2'(g), data: b[7:0], hdr: 1'b0, ends: e});
            end
            m_ptr = (g + 1) % NR;
        end
    endtask

    task automatic cycle();
        exp_t       e;
        logic [8:0] b;
        @(negedge clk);
        cyc++;
        uart_tx_done = 1'b0;
        if (busy_chk_pend) begin
            check_eq("busy_after_done", 32'(busy), 32'(busy_exp));
            busy_chk_pend = 0;
        end
        if (uart_send) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_send", 32'(uart_send), 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("[TB] send id=%0d data=%02h%s", grant_id, uart_data, e.hdr ? " header" : "");
                check_eq("uart_data", 32'(uart_data), 32'(e.data));
                check_eq("grant_id", 32'(grant_id), 32'(e.id));
                check_eq("busy_in_burst", 32'(busy), 32'd1);
                check_eq("req_ready", 32'(req_ready), e.hdr ? 32'd0 : (32'd1 << e.id));
                if (gap_track && !stall_since) check_eq("done_to_send", 32'(cyc - done_cyc), 32'd2);
                if (resume_pend) check_eq("resume_to_send", 32'(cyc - resume_cyc), 32'd1);
                cur_ends = e.ends;
            end
            gap_track   = 0;
            resume_pend = 0;
            uart_pend   = 1;
            uart_cnt    = $urandom_range(1, 4);
            cap_data    = uart_data;
        end else begin
            check_eq("ready_without_send", 32'(req_ready), 32'd0);
            if (uart_pend) begin
                check_eq("data_stable", 32'(uart_data), 32'(cap_data));
                uart_cnt--;
                if (uart_cnt == 0) begin
                    uart_tx_done  = 1'b1;
                    uart_pend     = 0;
                    busy_chk_pend = 1;
                    busy_exp      = !cur_ends;
                    done_cyc      = cyc;
                    gap_track     = (exp_q.size() != 0);
                    stall_since   = 0;
                end
            end
        end
        // Requesters: pop on ready; a stall is only legal while the burst is sure to continue.
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i] && rq[i].size() > 0) begin
                b = rq[i].pop_front();
                ready_cnt[i]++;
                dcnt[i]++;
                if (b[8] || dcnt[i] == BMAX) dcnt[i] = 0;
                else if (stall_mode == 2) stall_cnt[i] = 20;
                else if (stall_mode == 1 && $urandom_range(0, 3) == 0) stall_cnt[i] = $urandom_range(1, 6);
            end
            if (stall_cnt[i] > 0) begin
                stall_cnt[i]--;
                stall_since = 1;
                if (stall_cnt[i] == 0 && !uart_pend && !uart_tx_done && !uart_send) begin
                    resume_pend = 1;
                    resume_cyc  = cyc;
                end
            end
            req_valid[i]       = (rq[i].size() > 0) && (stall_cnt[i] == 0);
            req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
            req_last[i]        = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
        end
    endtask

    task automatic run_round(input string name);
        int budget;
        build_expected();
        budget = 0;
        while ((exp_q.size() != 0 || uart_pend || busy_chk_pend) && budget < 4000) begin
            cycle();
            budget++;
        end
        check_eq({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        cycle();
        uart_tx_done = 1'b1;  // stray completion while idle must be ignored
        cycle();
        cycle();
        cycle();
        check_eq({name, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check_eq({name, "_req_ready"}, 32'(req_ready), 32'd0);
        check_eq({name, "_grant_id"}, 32'(grant_id), 32'd0);
        check_eq({name, "_busy"}, 32'(busy), 32'd0);
        check_eq({name, "_uart_send"}, 32'(uart_send), 32'd0);
        check_eq({name, "_uart_data"}, 32'(uart_data), 32'd0);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        clear_tb();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Round-robin 0,1,3 twice
        for (int r = 0; r < 2; r++) begin
            rq[0].push_back(9'h130);
            rq[1].push_back(9'h131);
            rq[3].push_back(9'h133);
            run_round("round_robin");
        end

        // Single burst on lane 0
        for (int i = 0; i < NR; i++) ready_cnt[i] = 0;
        rq[0].push_back(9'h055);
        rq[0].push_back(9'h0AA);
        rq[0].push_back(9'h10F);
        run_round("single");
        check_eq("ready0_count", 32'(ready_cnt[0]), 32'd3);

        // Pointer left at 1: lane 1 must win over lane 0
        rq[0].push_back(9'h1C0);
        rq[1].push_back(9'h1C1);
        run_round("ptr_after_single");

        // Forced release after BMAX bytes from lane 2 while lane 3 waits
        for (int j = 0; j < 6; j++) rq[2].push_back({(j == 5), 8'(8'h20 + j)});
        rq[3].push_back(9'h1D3);
        run_round("forced_release");

        // 20-cycle valid gap mid-burst on lane 1
        stall_mode = 2;
        rq[1].push_back(9'h011);
        rq[1].push_back(9'h122);
        run_round("stall");
        stall_mode = 0;

`ifdef UART_TX_ID_HEADER_EN
        for (int i = 0; i < NR; i++) ready_cnt[i] = 0;
        rq[2].push_back(9'h141);
        run_round("header");
        check_eq("ready2_count", 32'(ready_cnt[2]), 32'd1);
`endif

        // Reset while a byte is waiting for tx_done
        rq[1].push_back(9'h131);
        run_round("pre_reset");
        rq[2].push_back(9'h021);
        rq[2].push_back(9'h022);
        rq[2].push_back(9'h123);
        build_expected();
        guard = 0;
        while (!uart_pend && guard < 50) begin
            cycle();
            guard++;
        end
        check_eq("pre_reset_send_seen", 32'(uart_pend), 32'd1);
        uart_cnt = 100;
        cycle();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        clear_tb();
        repeat (3) @(negedge clk);
        check_eq("reset_hold_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        rq[3].push_back(9'h1B3);
        rq[1].push_back(9'h1B1);
        run_round("after_reset");

        // Randomized rounds with random stalls
        stall_mode = 1;
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(0, 2) != 0) begin
                    for (int m = 0; m < int'($urandom_range(1, 2)); m++) push_msg(i, $urandom_range(1, 6));
                end
            end
            run_round("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART_TX byte transmitter among NUM_REQ requesters.
- Grants the transmitter to one requester for a burst of bytes. Each byte is issued as a one-cycle send pulse, and the block waits for the transmitter's one-cycle tx_done pulse before issuing the next byte.
- Sits between the on-chip byte sources (command responder, status reporter, debug dump) and the single UART_TX instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the granted-ID field; must equal clog2(NUM_REQ).
- BURST_MAX, 16, maximum bytes per grant before a forced release (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  requester i has a byte on its data lane.
- req_data  input  8*NUM_REQ  byte lanes; lane i = bits [8*i+7:8*i].
- req_last  input  NUM_REQ  byte on lane i ends requester i's burst.
- req_ready  output  NUM_REQ  one-hot, one-cycle pulse: lane i's byte has been accepted.
- grant_id  output  ID_W  index of the current owner; valid while busy=1.
- busy  output  1  a grant is active.
- uart_send  output  1  one-cycle pulse to UART_TX send.
- uart_data  output  8  byte to UART_TX data_in; stable from the send pulse until tx_done.
- uart_tx_done  input  1  one-cycle completion pulse from UART_TX.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst_n is asynchronous and active-low.
  - Reset values: req_ready=0, grant_id=0, busy=0, uart_send=0, uart_data=8'h00, round-robin pointer=0, burst counter=0, FSM=IDLE.
- States: IDLE, ISSUE, WAIT_DONE, NEXT (plus HDR when the optional feature is enabled).
- IDLE:
  - If any req_valid is high, pick the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Latch that index into grant_id, set busy=1, clear the burst counter, go to ISSUE.
  - With no request, stay in IDLE with busy=0.
- ISSUE (one cycle, entered only when req_valid[grant_id]=1):
  - Register uart_data from the lane and pulse uart_send.
  - Pulse req_ready[grant_id]; the requester presents its next byte, or drops valid, on the following cycle.
  - Latch the last flag, increment the burst counter, go to WAIT_DONE.
- WAIT_DONE:
  - Hold uart_data and wait for uart_tx_done.
  - On tx_done: if last was latched or burst counter == BURST_MAX, go to IDLE, clear busy, and set pointer = grant_id+1 mod NUM_REQ. Otherwise go to NEXT.
- NEXT:
  - If req_valid[grant_id]=1, go to ISSUE.
  - Otherwise wait with the grant held; no timeout.
  - Other requesters are never served mid-burst.
- Latency: grant decision to uart_send pulse is 1 cycle (IDLE→ISSUE). tx_done to the next uart_send is 2 cycles (NEXT→ISSUE).
- Simultaneous events:
  - A request arriving in the same cycle as a release is arbitrated on the next IDLE cycle, using the updated pointer.
  - A tx_done pulse outside WAIT_DONE is ignored.
- Requester rules:
  - req_data and req_last are sampled only in ISSUE.
  - A valid that drops outside ISSUE is legal.
- Fairness: a requester holding valid continuously waits at most NUM_REQ-1 bursts.
- Reset mid-transfer: the FSM returns to IDLE immediately and the next send starts clean. UART_TX must share the system reset source.
- Width rules: the burst counter is 8 bits. The BURST_MAX comparison is an exact equality, so the counter never wraps.

Optional Feature:
- Macro: UART_TX_ID_HEADER_EN.
- When defined:
  - Each grant starts in HDR instead of ISSUE.
  - HDR sends header byte {4'hA, (4-ID_W)'b0, grant_id} via uart_send with no req_ready pulse, waits for tx_done, then goes to NEXT.
  - The header does not count toward BURST_MAX.
- When undefined: HDR is absent and IDLE goes directly to ISSUE.

Test Plan:
- Single burst: req 0 sends 8'h55, 8'hAA, then 8'h0F with last. Required: three uart_send pulses with uart_data = 55, AA, 0F; three req_ready[0] pulses; busy falls 1 cycle after the third tx_done; pointer=1.
- Round-robin: req 0, 1 and 3 all valid with single-byte last bursts. Required: service order 0,1,3. Re-asserting all three then gives 0,1,3 again, with no starvation of 3.
- Forced release: BURST_MAX=4; req 2 streams 6 bytes without last while req 3 waits. Required: 4 bytes from lane 2, then grant_id=3, then lane 2's remaining bytes on its next turn.
- Stall mid-burst: req 1 drops valid for 20 cycles after byte 1. Required: grant held, no uart_send during the gap, no other requester served, byte 2 issued 1 cycle after valid returns.
- Reset in WAIT_DONE: assert rst_n=0 for 3 cycles. Required: all outputs at reset values immediately (asynchronous), pointer=0, next request served normally.
- With UART_TX_ID_HEADER_EN defined: req 2 sends one byte 8'h41 with last (NUM_REQ=4). Required: uart_data sequence A2, 41; exactly one req_ready[2] pulse.
